jtag_request_arbiter: RTL and testbench

//  Shares the single JTAG master between NUM_REQ configuration requesters (VIO TDC/ASD config, config loop, status reads).

---
 rtl/jtag_request_arbiter.sv | 97 +++++++++
 tb/tb_jtag_request_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_request_arbiter.sv
// jtag_request_arbiter: round-robin sharing of one JTAG master among NUM_REQ requesters
module jtag_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 3,
  parameter int TMO_W     = 24,
  parameter int BUSY_WAIT = 64,
  parameter int RUN_TMO   = 16000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] start,
  input  logic               jtag_busy,
  input  logic               tdi_tdo_equal,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] pass,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               arb_busy,
  output logic               timeout_err
);
  typedef enum logic [2:0] {IDLE, GRANT, WAIT_BUSY, RUN, DONE, DONE_HOLD} state_t;
  state_t             r_state, w_next;
  logic [NUM_REQ-1:0] r_pending, r_pass, w_onehot, w_pick_onehot;
  logic [IDX_W-1:0]   r_grant_idx, w_pick;
  logic [TMO_W-1:0]   r_cnt;
  logic               r_timeout, w_found, w_go, w_fin, w_res, w_tmo, w_cnt_clr;
  // search grant_idx+1, +2, ... so the most recently served requester ranks last
  always_comb begin
    w_pick  = r_grant_idx;
    w_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (|(r_pending & (NUM_REQ'(1) << ((int'(r_grant_idx) + k) % NUM_REQ)))) begin
        w_pick  = IDX_W'((int'(r_grant_idx) + k) % NUM_REQ);
        w_found = 1'b1;
      end
  end
  assign w_onehot      = NUM_REQ'(1) << r_grant_idx;
  assign w_pick_onehot = NUM_REQ'(1) << w_pick;
  always_comb begin
    w_next    = r_state;
    w_go      = 1'b0;
    w_res     = 1'b0;
    w_tmo     = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      IDLE: if (enable && w_found && !jtag_busy) begin
        w_go   = 1'b1;
        w_next = GRANT;
      end
      GRANT: begin
        w_next    = WAIT_BUSY;
        w_cnt_clr = 1'b1;
      end
      WAIT_BUSY: if (jtag_busy) begin
        w_next    = RUN;
        w_cnt_clr = 1'b1;
      end else if (r_cnt == TMO_W'(BUSY_WAIT - 1)) begin
        w_next = DONE;
        w_tmo  = 1'b1;
      end
      RUN: if (!jtag_busy) begin
        w_next = DONE;
        w_res  = tdi_tdo_equal;
      end else if (r_cnt == TMO_W'(RUN_TMO - 1)) begin
        w_next = DONE;
        w_tmo  = 1'b1;
      end
      DONE:      w_next = jtag_busy ? DONE_HOLD : IDLE;
      DONE_HOLD: w_next = jtag_busy ? DONE_HOLD : IDLE;
      default:   w_next = IDLE;
    endcase
    w_fin = (w_next == DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_pass      <= '0;
      r_grant_idx <= IDX_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pending   <= (r_pending & ~(w_go ? w_pick_onehot : '0)) | req;
      r_grant_idx <= w_go ? w_pick : r_grant_idx;
      r_cnt       <= w_cnt_clr ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
      r_timeout   <= r_timeout | w_tmo;
      r_pass      <= w_fin ? ((r_pass & ~w_onehot) | (w_res ? w_onehot : '0)) : r_pass;
    end
  assign start       = (r_state == GRANT) ? w_onehot : '0;
  assign done        = (r_state == DONE) ? w_onehot : '0;
  assign pass        = r_pass;
  assign grant_idx   = r_grant_idx;
  assign arb_busy    = (r_state != IDLE);
  assign timeout_err = r_timeout;
endmodule

// File: tb/tb_jtag_request_arbiter.sv
// tb_jtag_request_arbiter: directed checks of grant order, timing, timeouts, enable and reset
module tb_jtag_request_arbiter;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b1, jtag_busy = 1'b0, tdi_tdo_equal = 1'b0;
  logic [3:0] req = '0, start, done, pass, acc_s, acc_d;
  logic [2:0] grant_idx;
  logic       arb_busy, timeout_err;
  int         checks = 0, errors = 0;

  jtag_request_arbiter #(.NUM_REQ(4), .IDX_W(3), .TMO_W(8), .BUSY_WAIT(8), .RUN_TMO(150)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .start(start), .jtag_busy(jtag_busy),
    .tdi_tdo_equal(tdi_tdo_equal), .done(done), .pass(pass), .grant_idx(grant_idx),
    .arb_busy(arb_busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [3:0] exp, input logic res, input string tag);
    int n = 0;
    while (start == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " start"}, start, exp);
    jtag_busy = 1'b1;
    tdi_tdo_equal = res;
    repeat (3) tick();
    jtag_busy = 1'b0;
    tick();
    chk({tag, " done"}, done, exp);
    chk({tag, " pass"}, pass & exp, res ? exp : 4'b0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst start", start, 4'b0);
    chk("rst done", done, 4'b0);
    chk("rst pass", pass, 4'b0);
    chk("rst grant_idx", 4'(grant_idx), 4'd3);
    chk("rst arb_busy", 4'(arb_busy), 4'd0);
    chk("rst timeout", 4'(timeout_err), 4'd0);
    rst = 1'b0;
    tick();
    // single request, 100-cycle busy
    req = 4'b0001;
    tick();
    req = 4'b0000;
    chk("t1 start early", start, 4'b0);
    tick();
    chk("t1 start", start, 4'b0001);
    chk("t1 grant_idx", 4'(grant_idx), 4'd0);
    chk("t1 arb_busy", 4'(arb_busy), 4'd1);
    jtag_busy = 1'b1;
    tdi_tdo_equal = 1'b1;
    acc_d = '0;
    repeat (100) begin
      tick();
      acc_d |= done;
    end
    chk("t1 no early done", acc_d, 4'b0);
    jtag_busy = 1'b0;
    tick();
    chk("t1 done", done, 4'b0001);
    chk("t1 pass", pass, 4'b0001);
    chk("t1 arb_busy at done", 4'(arb_busy), 4'd1);
    tick();
    chk("t1 done cleared", done, 4'b0);
    chk("t1 arb_busy low", 4'(arb_busy), 4'd0);
    // round robin from grant_idx=3, then from grant_idx=0
    do_reset();
    req = 4'b1011;
    tick();
    req = 4'b0000;
    serve(4'b0001, 1'b1, "t2a g0");
    serve(4'b0010, 1'b0, "t2a g1");
    serve(4'b1000, 1'b1, "t2a g3");
    chk("t2a pass all", pass, 4'b1001);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    serve(4'b0001, 1'b1, "t2b g0");
    req = 4'b1011;
    tick();
    req = 4'b0000;
    serve(4'b0010, 1'b1, "t2b g1");
    serve(4'b1000, 1'b0, "t2b g3");
    serve(4'b0001, 1'b0, "t2b g0b");
    chk("t2b pass all", pass, 4'b0010);
    // no busy response -> BUSY_WAIT timeout
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("t3 start", start, 4'b0100);
    acc_d = '0;
    repeat (8) begin
      tick();
      acc_d |= done;
    end
    chk("t3 no early done", acc_d, 4'b0);
    tick();
    chk("t3 done", done, 4'b0100);
    chk("t3 pass", pass & 4'b0100, 4'b0);
    chk("t3 timeout", 4'(timeout_err), 4'd1);
    repeat (3) tick();
    chk("t3 timeout sticky", 4'(timeout_err), 4'd1);
    // busy stuck past RUN_TMO; queued request waits for busy to fall
    do_reset();
    req = 4'b0011;
    tick();
    req = 4'b0000;
    tick();
    chk("t4 start", start, 4'b0001);
    jtag_busy = 1'b1;
    tdi_tdo_equal = 1'b1;
    acc_d = '0;
    acc_s = '0;
    repeat (200) begin
      tick();
      acc_d |= done;
      acc_s |= start;
    end
    chk("t4 done seen", acc_d, 4'b0001);
    chk("t4 no start while busy", acc_s, 4'b0);
    chk("t4 pass", pass, 4'b0);
    chk("t4 timeout", 4'(timeout_err), 4'd1);
    chk("t4 arb_busy hold", 4'(arb_busy), 4'd1);
    jtag_busy = 1'b0;
    tick();
    chk("t4 idle", 4'(arb_busy), 4'd0);
    tick();
    chk("t4 next start", start, 4'b0010);
    serve(4'b0010, 1'b1, "t4 g1");
    // enable gating and merge of a repeat request during the run
    enable = 1'b0;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    acc_s = '0;
    repeat (5) begin
      tick();
      acc_s |= start;
    end
    chk("t5 no start disabled", acc_s, 4'b0);
    enable = 1'b1;
    tick();
    chk("t5 start after enable", start, 4'b0100);
    jtag_busy = 1'b1;
    tick();
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    jtag_busy = 1'b0;
    tick();
    chk("t5 done", done, 4'b0100);
    serve(4'b0100, 1'b1, "t5 regrant");
    acc_s = '0;
    repeat (10) begin
      tick();
      acc_s |= start;
    end
    chk("t5 single regrant", acc_s, 4'b0);
    // reset while running with a request pending
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    chk("t6 start", start, 4'b0010);
    jtag_busy = 1'b1;
    tick();
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    chk("t6 pre-rst pass", pass, 4'b0110);
    rst = 1'b1;
    #1;
    chk("t6 rst start", start, 4'b0);
    chk("t6 rst done", done, 4'b0);
    chk("t6 rst pass", pass, 4'b0);
    chk("t6 rst arb_busy", 4'(arb_busy), 4'd0);
    chk("t6 rst timeout", 4'(timeout_err), 4'd0);
    chk("t6 rst grant_idx", 4'(grant_idx), 4'd3);
    jtag_busy = 1'b0;
    tick();
    rst = 1'b0;
    acc_s = '0;
    repeat (10) begin
      tick();
      acc_s |= start;
    end
    chk("t6 pending discarded", acc_s, 4'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
